// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single-port 64x32 unified instruction/data memory between the
// instruction-fetch path (read-only) and the load/store path (read/write).
// Each access runs request -> grant -> memory cycle -> read response, with
// exactly one transaction in flight. Loads/stores normally win arbitration,
// but a streak counter forces fetch through after MAX_D_STREAK consecutive
// data grants taken while fetch was waiting.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   if_req/if_addr    fetch request and byte address
//   if_gnt            fetch accepted this cycle (combinational, IDLE only)
//   if_rvalid/rdata   fetch response pulse and held fetch data
//   d_req/d_we/...    load/store request, direction, byte address, store data
//   d_gnt             load/store accepted this cycle (combinational, IDLE only)
//   d_rvalid/d_rdata  load response pulse and held load data
//   mem_*             memory strobe, write enable, word index, write data,
//                     synchronous read data (valid the cycle after mem_en)
//   busy              a transaction is in flight
module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 2,
  parameter int WORD_AW      = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [31:0]        if_addr,
  output logic               if_gnt,
  output logic               if_rvalid,
  output logic [31:0]        if_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [31:0]        d_addr,
  input  logic [31:0]        d_wdata,
  output logic               d_gnt,
  output logic               d_rvalid,
  output logic [31:0]        d_rdata,
  output logic               mem_en,
  output logic               mem_we,
  output logic [WORD_AW-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

  state_t               r_state;
  logic [3:0]           r_streak;
  logic                 r_src_d;      // 1: data port owns the transaction
  logic                 r_mem_en;
  logic                 r_mem_we;
  logic [WORD_AW-1:0]   r_mem_addr;
  logic [31:0]          r_mem_wdata;
  logic                 r_if_rvalid;
  logic                 r_d_rvalid;
  logic [31:0]          r_if_rdata;
  logic [31:0]          r_d_rdata;
  logic                 r_busy;

  logic                 w_d_win;
  logic                 w_if_win;
  logic                 w_unused;

  // Byte-offset bits and bits above the word index do not select a word.
  assign w_unused = ^{if_addr[31:WORD_AW+2], if_addr[1:0],
                      d_addr[31:WORD_AW+2], d_addr[1:0]};

  // Arbitration: data wins unless fetch is waiting and the data streak is full.
  always_comb begin
    w_d_win  = 1'b0;
    w_if_win = 1'b0;
    if (r_state == ST_IDLE) begin
      if (d_req && (!if_req || (r_streak != MAX_STREAK))) begin
        w_d_win = 1'b1;
      end else if (if_req) begin
        w_if_win = 1'b1;
      end else begin
        w_d_win  = 1'b0;
        w_if_win = 1'b0;
      end
    end else begin
      w_d_win  = 1'b0;
      w_if_win = 1'b0;
    end
  end

  // Transaction FSM: capture on grant, drive memory in ACCESS, respond in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_streak    <= 4'd0;
      r_src_d     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_if_rdata  <= 32'd0;
      r_d_rdata   <= 32'd0;
      r_busy      <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_d_win) begin
            r_state     <= ST_ACCESS;
            r_busy      <= 1'b1;
            r_src_d     <= 1'b1;
            r_mem_en    <= 1'b1;
            r_mem_we    <= d_we;
            r_mem_addr  <= d_addr[WORD_AW+1:2];
            r_mem_wdata <= d_wdata;
            // Streak only grows while fetch is actually being held off.
            if (!if_req) begin
              r_streak <= 4'd0;
            end else if (r_streak == MAX_STREAK) begin
              r_streak <= r_streak;
            end else begin
              r_streak <= r_streak + 4'd1;
            end
          end else if (w_if_win) begin
            r_state     <= ST_ACCESS;
            r_busy      <= 1'b1;
            r_src_d     <= 1'b0;
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr[WORD_AW+1:2];
            r_mem_wdata <= 32'd0;
            r_streak    <= 4'd0;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_ACCESS: begin
          // r_mem_we still holds the captured direction during ACCESS.
          if (r_mem_we) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_RESP;
            if (r_src_d) begin
              r_d_rvalid <= 1'b1;
            end else begin
              r_if_rvalid <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          if (r_src_d) begin
            r_d_rdata <= mem_rdata;
          end else begin
            r_if_rdata <= mem_rdata;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign if_gnt    = w_if_win;
  assign d_gnt     = w_d_win;
  assign if_rvalid = r_if_rvalid;
  assign d_rvalid  = r_d_rvalid;
  // Memory data arrives during RESP; pass it through then, hold it afterwards.
  assign if_rdata  = r_if_rvalid ? mem_rdata : r_if_rdata;
  assign d_rdata   = r_d_rvalid  ? mem_rdata : r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_if = 32'd0;
  logic [31:0] last_d  = 32'd0;

  mem_port_arbiter #(.MAX_D_STREAK(2), .WORD_AW(6)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory: read data valid the cycle after mem_en.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct {
    logic        ifr;
    logic [31:0] ia;
    logic        dr;
    logic        we;
    logic [31:0] da;
    logic [31:0] wd;
    logic        exp_d;     // 1: data port must win
    logic [5:0]  exp_addr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // One isolated transaction; entered and left at posedge+1 of an IDLE cycle.
  task automatic do_txn(input vec_t t);
    logic exp_we;
    exp_we  = t.exp_d & t.we;
    if_req  = t.ifr; if_addr = t.ia;
    d_req   = t.dr;  d_we = t.we; d_addr = t.da; d_wdata = t.wd;
    @(negedge clk);
    chk("if_gnt", 32'(if_gnt), 32'(!t.exp_d));
    chk("d_gnt", 32'(d_gnt), 32'(t.exp_d));
    @(posedge clk); #1;
    // Scramble inputs: captured fields must not follow them.
    if_req = 1'b0; d_req = 1'b0;
    if_addr = 32'hFFFF_FFFF; d_addr = 32'hFFFF_FFFF;
    d_wdata = 32'h0BAD_0BAD; d_we = ~d_we;
    @(negedge clk);
    chk("access_en_busy", 32'({mem_en, busy, if_gnt | d_gnt}), 32'(3'b110));
    chk("access_we", 32'(mem_we), 32'(exp_we));
    chk("access_addr", 32'(mem_addr), 32'(t.exp_addr));
    if (exp_we) chk("access_wdata", mem_wdata, t.wd);
    @(posedge clk); #1;
    @(negedge clk);
    if (!exp_we) begin
      if (t.exp_d) begin
        chk("resp_rvalid", 32'({if_rvalid, d_rvalid}), 32'(2'b01));
        chk("d_rdata", d_rdata, t.exp_rd);
        chk("if_rdata_hold", if_rdata, last_if);
        last_d = t.exp_rd;
      end else begin
        chk("resp_rvalid", 32'({if_rvalid, d_rvalid}), 32'(2'b10));
        chk("if_rdata", if_rdata, t.exp_rd);
        chk("d_rdata_hold", d_rdata, last_d);
        last_if = t.exp_rd;
      end
    end else begin
      chk("write_done", 32'({busy, if_rvalid, d_rvalid}), 32'(3'b000));
    end
    @(posedge clk); #1;
    d_we = 1'b0;
  endtask

  // Record the order of the next n grants (1 = data) with requests held.
  task automatic collect(input int n, output logic [7:0] seq);
    int got;
    got = 0;
    seq = 8'd0;
    for (int c = 0; c < 10 * n && got < n; c++) begin
      @(negedge clk);
      chk("gnt_exclusive", 32'(if_gnt & d_gnt), 32'd0);
      if (d_gnt) begin
        seq[got[2:0]] = 1'b1; got++;
      end else if (if_gnt) begin
        seq[got[2:0]] = 1'b0; got++;
      end
      if (got < n) begin
        @(posedge clk); #1;
      end
    end
    chk("grant_count", 32'(got), 32'(n));
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] seq;
    vec_t dl;

    vecs[0] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 1'b1, 6'd2,  32'h0};
    vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0100, 32'hA5A5_0000, 1'b1, 6'd0,  32'h0};
    vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 1'b1, 6'd63, 32'h0};
    vecs[3] = '{1'b1, 32'h0000_0008, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 6'd2, 32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0014, 32'h1234_5678, 1'b1, 6'd5,  32'h0};
    vecs[5] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0014, 32'h0, 1'b1, 6'd5,  32'h1234_5678};
    vecs[6] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0103, 32'h0, 1'b1, 6'd0,  32'hA5A5_0000};
    vecs[7] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_00FF, 32'h0, 1'b1, 6'd63, 32'hCAFE_F00D};
    vecs[8] = '{1'b1, 32'h0000_01FC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 6'd63, 32'hCAFE_F00D};
    vecs[9] = '{1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b1, 6'd2, 32'hDEAD_BEEF};

    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    #2;
    chk("reset_ctrl", 32'({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy, mem_addr}), 32'd0);
    chk("reset_if_rdata", if_rdata, 32'd0);
    chk("reset_d_rdata", d_rdata, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 10; i++) do_txn(vecs[i]);

    // Reset during a load's ACCESS cycle (streak is 1, becomes 2 on this grant).
    if_req = 1'b1; if_addr = 32'h14; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14;
    @(negedge clk);
    chk("rst_txn_gnt", 32'({if_gnt, d_gnt}), 32'(2'b01));
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    #2;
    chk("rst_pre_en", 32'(mem_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_ctrl", 32'({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy, mem_addr}), 32'd0);
    chk("rst_async_d_rdata", d_rdata, 32'd0);
    chk("rst_async_if_rdata", if_rdata, 32'd0);
    last_if = 32'd0; last_d = 32'd0;
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_no_rvalid", 32'({if_rvalid, d_rvalid, busy}), 32'd0);
    end
    @(posedge clk); #1;

    // Contention with both requests held: D, D, F, D, D, F (streak cleared by reset).
    if_req = 1'b1; if_addr = 32'h08; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14;
    collect(6, seq);
    chk("contention_order", 32'(seq), 32'h1B);
    last_if = 32'hDEAD_BEEF; last_d = 32'h1234_5678;

    // Five lone data loads keep the streak at zero; then fetch joins: D, D, F.
    dl = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0014, 32'h0, 1'b1, 6'd5, 32'h1234_5678};
    repeat (5) do_txn(dl);
    if_req = 1'b1; if_addr = 32'hFC; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14;
    collect(3, seq);
    chk("late_fetch_order", 32'(seq), 32'h03);
    last_if = 32'hCAFE_F00D;

    do_txn(vecs[3]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
